// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, the write-arbiter state encoding and
// the {rd, data} record buffered for deferred MDU writes.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } rf_wr_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: DEPTH-entry synchronous FIFO of pending MDU register writes.
// The head entry is presented combinationally; push and pop must only be
// issued when not full / not empty respectively.
module rf_arb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  rf_wr_t push_entry,
    input  logic   pop,
    output rf_wr_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wr_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Storage is data only; stale contents are never visible because count gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file write port between the WB stage
// (priority) and buffered MDU results. An age counter forces a one-cycle
// pipeline stall so a starved MDU result is written.
// Optional build macro RF_ARB_DROP_X0_EN: writes to x0 are discarded instead
// of arbitrated (WB x0 requests free the slot, MDU x0 results are not stored).
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  mdu_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]       rf_wd3,
    output logic                  stall_o,
    output logic                  grant_mdu
);

    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    arb_state_e        state, state_next;
    logic [AGE_W-1:0]  age, age_next, age_inc;
    logic              fifo_full, fifo_empty;
    rf_wr_t            head;
    logic              push_fire, push_store, pop;
    logic              wb_req, grant_wb, grant_head, stall;

    assign mdu_ready = rst & ~fifo_full;
    assign push_fire = mdu_valid & mdu_ready;

`ifdef RF_ARB_DROP_X0_EN
    assign wb_req     = wb_we & (wb_rd != '0);
    assign push_store = push_fire & (mdu_rd != '0);
`else
    assign wb_req     = wb_we;
    assign push_store = push_fire;
`endif

    assign pop = grant_head;

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_store),
        .push_entry ('{rd: mdu_rd, data: mdu_data}),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Saturating increment: the age never wraps back to zero on its own.
    assign age_inc = (age == AGE_W'(MAX_WAIT)) ? age : age + AGE_W'(1);

    // State and age registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            age   <= '0;
        end else begin
            state <= state_next;
            age   <= age_next;
        end
    end

    // Grant decision, age update and next state.
    always_comb begin
        state_next = state;
        age_next   = age;
        grant_wb   = 1'b0;
        grant_head = 1'b0;
        stall      = 1'b0;
        case (state)
            ARB: begin
                if (wb_req) begin
                    grant_wb = 1'b1;
                    if (!fifo_empty) begin
                        age_next = age_inc;
                        if (age == AGE_W'(MAX_WAIT - 1)) state_next = FORCE;
                    end
                end else if (!fifo_empty) begin
                    grant_head = 1'b1;
                    age_next   = '0;
                end else begin
                    age_next = '0;
                end
            end
            FORCE: begin
                stall      = 1'b1;
                grant_head = ~fifo_empty;
                age_next   = '0;
                state_next = ARB;
            end
        endcase
    end

    // Write port is driven combinationally from the grant; all zero in reset.
    always_comb begin
        rf_we     = 1'b0;
        rf_a3     = '0;
        rf_wd3    = '0;
        stall_o   = 1'b0;
        grant_mdu = 1'b0;
        if (rst) begin
            stall_o   = stall;
            grant_mdu = grant_head;
            if (grant_head) begin
                rf_we  = 1'b1;
                rf_a3  = head.rd;
                rf_wd3 = head.data;
            end else if (grant_wb) begin
                rf_we  = 1'b1;
                rf_a3  = wb_rd;
                rf_wd3 = wb_data;
            end
        end
    end

`ifndef SYNTHESIS
    hazard_chk: assert property (@(posedge clk) disable iff (!rst)
        !(wb_we && !fifo_empty && (wb_rd != '0) && (head.rd != '0) && (wb_rd == head.rd)))
        else $error("WB writes rd %0d while it is pending in the MDU FIFO", wb_rd);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed vector table, reset and x0
// sequences, then randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        stall_o;
    logic        grant_mdu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
        .stall_o(stall_o), .grant_mdu(grant_mdu)
    );

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        mdu_valid;
        logic [4:0]  mdu_rd;
        logic [31:0] mdu_data;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3;
        logic        e_stall;
        logic        e_grant;
        logic        e_ready;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    vec_t tbl[$];

    // Reference model: pending MDU writes in arrival order, how many cycles in
    // a row the oldest one has been passed over, and a pending forced slot.
    ent_t mq[$];
    int   m_wait;
    bit   m_force;

    function automatic vec_t mk(logic we, logic [4:0] rd, logic [31:0] d,
                                logic mv, logic [4:0] mrd, logic [31:0] md,
                                logic ewe, logic [4:0] ea3, logic [31:0] ewd,
                                logic est, logic egr, logic erdy);
        vec_t v;
        v.wb_we = we; v.wb_rd = rd; v.wb_data = d;
        v.mdu_valid = mv; v.mdu_rd = mrd; v.mdu_data = md;
        v.e_we = ewe; v.e_a3 = ea3; v.e_wd3 = ewd;
        v.e_stall = est; v.e_grant = egr; v.e_ready = erdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ewe, input logic [4:0] ea3,
                              input logic [31:0] ewd, input logic est, input logic egr,
                              input logic erdy);
        check({tag, ".rf_we"},     {31'd0, rf_we},     {31'd0, ewe});
        check({tag, ".rf_a3"},     {27'd0, rf_a3},     {27'd0, ea3});
        check({tag, ".rf_wd3"},    rf_wd3,             ewd);
        check({tag, ".stall_o"},   {31'd0, stall_o},   {31'd0, est});
        check({tag, ".grant_mdu"}, {31'd0, grant_mdu}, {31'd0, egr});
        check({tag, ".mdu_ready"}, {31'd0, mdu_ready}, {31'd0, erdy});
    endtask

    function automatic bit wb_request();
        bit r;
        r = wb_we;
`ifdef RF_ARB_DROP_X0_EN
        if (wb_rd == 5'd0) r = 1'b0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wait  = 0;
        m_force = 1'b0;
    endtask

    task automatic model_out(output logic we, output logic [4:0] a3, output logic [31:0] wd,
                             output logic st, output logic gm, output logic rdy);
        we = 0; a3 = 0; wd = 0; st = 0; gm = 0;
        rdy = (mq.size() < DEPTH);
        if (m_force) begin
            st = 1;
            if (mq.size() > 0) begin we = 1; gm = 1; a3 = mq[0].rd; wd = mq[0].data; end
        end else if (wb_request()) begin
            we = 1; a3 = wb_rd; wd = wb_data;
        end else if (mq.size() > 0) begin
            we = 1; gm = 1; a3 = mq[0].rd; wd = mq[0].data;
        end
    endtask

    task automatic model_step();
        bit   head_written, accept, nonempty;
        ent_t e;
        nonempty = (mq.size() > 0);
        accept   = mdu_valid && (mq.size() < DEPTH);
        head_written = 1'b0;
        if (m_force) begin
            head_written = nonempty;
            m_force = 1'b0;
            m_wait  = 0;
        end else if (wb_request()) begin
            if (nonempty) begin
                if (m_wait == MAX_WAIT - 1) m_force = 1'b1;
                m_wait++;
            end
        end else begin
            head_written = nonempty;
            m_wait = 0;
        end
        if (head_written) void'(mq.pop_front());
        if (accept) begin
            e.rd = mdu_rd; e.data = mdu_data;
`ifdef RF_ARB_DROP_X0_EN
            if (mdu_rd != 5'd0) mq.push_back(e);
`else
            mq.push_back(e);
`endif
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        wb_we = we; wb_rd = rd; wb_data = d;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    endtask

    // Advance one clock: model commits at the same edge as the DUT.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic model_cycle(input string tag);
        logic ewe, est, egr, erdy;
        logic [4:0] ea3;
        logic [31:0] ewd;
        #1;
        model_out(ewe, ea3, ewd, est, egr, erdy);
        check_outs(tag, ewe, ea3, ewd, est, egr, erdy);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd7, 32'h5678);
        model_reset();
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle port
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                0, 0, 0,            0, 0, 1));
        tbl.push_back(mk(0, 0, 0,          1, 5, 32'hDEADBEEF,     0, 0, 0,            0, 0, 1));
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                1, 5, 32'hDEADBEEF, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                0, 0, 0,            0, 0, 1));
        // WB priority
        tbl.push_back(mk(0, 0, 0,          1, 7, 32'h22,           0, 0, 0,            0, 0, 1));
        tbl.push_back(mk(1, 3, 32'h11,     0, 0, 0,                1, 3, 32'h11,       0, 0, 1));
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                1, 7, 32'h22,       0, 1, 1));
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                0, 0, 0,            0, 0, 1));
        // Starvation: four WB grants with a pending head, one forced slot, held WB lands
        tbl.push_back(mk(1, 1, 32'hA1,     1, 9, 32'h99,           1, 1, 32'hA1,       0, 0, 1));
        tbl.push_back(mk(1, 2, 32'hA2,     0, 0, 0,                1, 2, 32'hA2,       0, 0, 1));
        tbl.push_back(mk(1, 3, 32'hA3,     0, 0, 0,                1, 3, 32'hA3,       0, 0, 1));
        tbl.push_back(mk(1, 4, 32'hA4,     0, 0, 0,                1, 4, 32'hA4,       0, 0, 1));
        tbl.push_back(mk(1, 5, 32'hA5,     0, 0, 0,                1, 5, 32'hA5,       0, 0, 1));
        tbl.push_back(mk(1, 6, 32'hA6,     0, 0, 0,                1, 9, 32'h99,       1, 1, 1));
        tbl.push_back(mk(1, 6, 32'hA6,     0, 0, 0,                1, 6, 32'hA6,       0, 0, 1));
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                0, 0, 0,            0, 0, 1));
        // Full FIFO: pop in the same cycle does not reopen the push
        tbl.push_back(mk(0, 0, 0,          1, 16, 32'h100,         0, 0, 0,            0, 0, 1));
        tbl.push_back(mk(1, 2, 32'hB2,     1, 17, 32'h101,         1, 2, 32'hB2,       0, 0, 1));
        tbl.push_back(mk(1, 2, 32'hB2,     1, 18, 32'h102,         1, 2, 32'hB2,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,          1, 18, 32'h102,         1, 16, 32'h100,     0, 1, 0));
        tbl.push_back(mk(0, 0, 0,          1, 18, 32'h102,         1, 17, 32'h101,     0, 1, 1));
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                1, 18, 32'h102,     0, 1, 1));
        tbl.push_back(mk(0, 0, 0,          0, 0, 0,                0, 0, 0,            0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].wb_we, tbl[i].wb_rd, tbl[i].wb_data,
                  tbl[i].mdu_valid, tbl[i].mdu_rd, tbl[i].mdu_data);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_a3, tbl[i].e_wd3,
                       tbl[i].e_stall, tbl[i].e_grant, tbl[i].e_ready);
            tick();
        end

        // Reset mid-operation with two entries buffered
        drive(1, 1, 32'hC1, 1, 20, 32'h2020);
        model_cycle("fill0");
        drive(1, 2, 32'hC2, 1, 21, 32'h2121);
        model_cycle("fill1");
        drive(1, 3, 32'hC3, 1, 22, 32'h2222);
        rst = 1'b0;
        #1;
        check_outs("mid_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_outs("post_reset0", 0, 0, 0, 0, 0, 1);
        tick();
        #1;
        check_outs("post_reset1", 0, 0, 0, 0, 0, 1);
        tick();

`ifdef RF_ARB_DROP_X0_EN
        // WB x0 request yields the slot to the pending head
        drive(0, 0, 0, 1, 24, 32'h2424);
        model_cycle("x0_push");
        drive(1, 0, 32'hFFFF, 0, 0, 0);
        #1;
        check_outs("x0_wb", 1, 24, 32'h2424, 0, 1, 1);
        tick();
        // MDU x0 result handshakes but never reaches the port
        drive(0, 0, 0, 1, 0, 32'h0BAD);
        #1;
        check_outs("x0_mdu_push", 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check_outs("x0_mdu_after", 0, 0, 0, 0, 0, 1);
        tick();
`endif

        // Randomized traffic; WB uses x1..x15 (and x0), MDU uses x16..x31 (and x0)
        for (int n = 0; n < 400; n++) begin
            logic        r_we, r_mv;
            logic [4:0]  r_rd, r_mrd;
            if (m_force) begin
                r_we = wb_we; r_rd = wb_rd;
            end else begin
                r_we = ($urandom % 4) != 0;
                r_rd = 5'($urandom % 16);
            end
            r_mv  = ($urandom % 2) == 1;
            r_mrd = (($urandom % 8) == 0) ? 5'd0 : 5'(16 + ($urandom % 16));
            drive(r_we, r_rd, m_force ? wb_data : $urandom, r_mv, r_mrd, $urandom);
            model_cycle($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
